// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM frame reader/writer pair: FSM state
// encodings, the default burst length and the 64-bit word pixel packing.
package sdram_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE       = 2'd0;
   localparam state_t ST_ISSUE      = 2'd1;
   localparam state_t ST_WAIT_SPACE = 2'd2;
   localparam state_t ST_FLUSH      = 2'd3;

   localparam int BURST_LEN_DEF = 32;

   // Each 64-bit word carries two 24-bit pixels; the upper one is shown first.
   localparam int PIX_W    = 24;
   localparam int PIX0_LSB = 32;
   localparam int PIX1_LSB = 0;
   localparam int R_LSB    = 0;
   localparam int G_LSB    = 8;
   localparam int B_LSB    = 16;

   typedef struct packed {
      logic [7:0] b;
      logic [7:0] g;
      logic [7:0] r;
   } pixel_t;

   function automatic pixel_t unpack_pixel(input logic [63:0] word, input logic second);
      logic [PIX_W-1:0] raw;
      pixel_t           p;
      raw = second ? word[PIX1_LSB +: PIX_W] : word[PIX0_LSB +: PIX_W];
      p.r = raw[R_LSB +: 8];
      p.g = raw[G_LSB +: 8];
      p.b = raw[B_LSB +: 8];
      return p;
   endfunction

endpackage

// File: rtl/sdram_read_fifo.sv
// Single-clock show-ahead FIFO for returned SDRAM words. The head word is
// always visible on rd_data_o; usedw_o reports occupancy and clr_i empties
// the FIFO on the next clock edge.
module sdram_read_fifo #(
   parameter int DEPTH = 256
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   clr_i,
   input  logic                   wr_en_i,
   input  logic [63:0]            wr_data_i,
   input  logic                   rd_en_i,
   output logic [63:0]            rd_data_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] usedw_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] LAST_SLOT = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

   logic [63:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_wr, do_rd;

   assign do_wr = wr_en_i && (count_q != DEPTH_C);
   assign do_rd = rd_en_i && (count_q != '0);

   // Pointer and occupancy next-state; clear overrides any push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PW'(1);
         if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + PW'(1);
         case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control registers; storage contents are left unreset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Word storage.
   always_ff @(posedge clk_i) begin
      if (do_wr && !clr_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign empty_o   = (count_q == '0);
   assign usedw_o   = count_q;

endmodule

// File: rtl/sdram_read_frame.sv
// Frame reader: issues Avalon read bursts from the buffer the writer is not
// filling, paces them by FIFO credit, and streams the returned words out as
// two RGB pixels each over a valid/ready interface.
module sdram_read_frame
   import sdram_pkg::*;
#(
   parameter int FRAME_WORDS = 1036800,
   parameter int BURST_LEN   = BURST_LEN_DEF,
   parameter int FIFO_DEPTH  = 256
) (
   input  logic        clk_100,
   input  logic        reset_n,
   input  logic        start_frame,
   input  logic        wr_buf,
   input  logic [31:0] reg_addr_buf_1,
   input  logic [31:0] reg_addr_buf_2,
   output logic [28:0] avl_address,
   output logic [7:0]  avl_burstcount,
   output logic        avl_read,
   input  logic        avl_waitrequest,
   input  logic [63:0] avl_readdata,
   input  logic        avl_readdatavalid,
   output logic [7:0]  r_out,
   output logic [7:0]  g_out,
   output logic [7:0]  b_out,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        end_frame
);

   localparam int WLW = $clog2(FRAME_WORDS + 1);
   localparam int OW  = $clog2(FIFO_DEPTH) + 1;
   localparam int PCW = $clog2(2 * FRAME_WORDS);

   localparam logic [WLW-1:0] FRAME_WL = WLW'(FRAME_WORDS);
   localparam logic [WLW-1:0] BURST_WL = WLW'(BURST_LEN);
   localparam logic [OW-1:0]  BURST_OW = OW'(BURST_LEN);
   localparam logic [28:0]    BURST_AW = 29'(BURST_LEN);
   localparam logic [PCW-1:0] LAST_PIX = PCW'(2 * FRAME_WORDS - 1);
   localparam logic [31:0]    BURST_32 = 32'(BURST_LEN);
   localparam logic [31:0]    DEPTH_32 = 32'(FIFO_DEPTH);

   state_t         state_q, state_d;
   logic [28:0]    addr_q, addr_d;
   logic [WLW-1:0] words_left_q, words_left_d;
   logic [OW-1:0]  outst_q, outst_d;
   logic           half_q, half_d;
   logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
   logic           end_frame_q, end_frame_d;

   logic           fifo_clr, fifo_wr, fifo_rd, fifo_empty;
   logic [63:0]    fifo_rdata;
   logic [OW-1:0]  fifo_usedw;

   logic           issue_accept, rdv_take, busy, credit_ok, pix_acc;
   logic [28:0]    base_sel;
   logic [31:0]    need_w;
   pixel_t         pix_w;
   logic           unused_bits;

   sdram_read_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i     (clk_100),
      .rst_n_i   (reset_n),
      .clr_i     (fifo_clr),
      .wr_en_i   (fifo_wr),
      .wr_data_i (avl_readdata),
      .rd_en_i   (fifo_rd),
      .rd_data_o (fifo_rdata),
      .empty_o   (fifo_empty),
      .usedw_o   (fifo_usedw)
   );

   // Handshake qualifiers, credit test and the pixel path.
   always_comb begin
      issue_accept = (state_q == ST_ISSUE) && !avl_waitrequest;
      // Data with nothing outstanding (e.g. left over from before a reset) is ignored.
      rdv_take     = avl_readdatavalid && (outst_q != '0);
      busy         = (outst_q != '0) || !fifo_empty || issue_accept;
      need_w       = 32'(fifo_usedw) + 32'(outst_q) + BURST_32;
      credit_ok    = (need_w <= DEPTH_32);
      base_sel     = wr_buf ? reg_addr_buf_1[28:0] : reg_addr_buf_2[28:0];

      pix_valid    = !fifo_empty && (state_q != ST_FLUSH);
      pix_acc      = pix_valid && pix_ready;
      pix_w        = unpack_pixel(fifo_rdata, half_q);
      r_out        = pix_valid ? pix_w.r : 8'd0;
      g_out        = pix_valid ? pix_w.g : 8'd0;
      b_out        = pix_valid ? pix_w.b : 8'd0;

      fifo_rd      = pix_acc && half_q;
      fifo_wr      = rdv_take && (state_q != ST_FLUSH) && !start_frame;
      fifo_clr     = start_frame || (state_q == ST_FLUSH);
   end

   // Burst sequencing FSM, outstanding-word tracking and pixel counting.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      words_left_d = words_left_q;
      outst_d      = outst_q + (issue_accept ? BURST_OW : '0) - (rdv_take ? OW'(1) : '0);
      half_d       = half_q;
      pix_cnt_d    = pix_cnt_q;
      end_frame_d  = pix_acc && (pix_cnt_q == LAST_PIX);

      if (pix_acc) begin
         half_d    = !half_q;
         pix_cnt_d = (pix_cnt_q == LAST_PIX) ? '0 : pix_cnt_q + PCW'(1);
      end

      if (start_frame) begin
         // A burst accepted in this same cycle still counts as outstanding.
         addr_d       = base_sel;
         words_left_d = FRAME_WL;
         half_d       = 1'b0;
         pix_cnt_d    = '0;
         state_d      = busy ? ST_FLUSH : ST_WAIT_SPACE;
      end else begin
         case (state_q)
            ST_WAIT_SPACE: begin
               if ((words_left_q != '0) && credit_ok) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
               if (issue_accept) begin
                  addr_d       = addr_q + BURST_AW;
                  words_left_d = words_left_q - BURST_WL;
                  state_d      = (words_left_q == BURST_WL) ? ST_IDLE : ST_WAIT_SPACE;
               end
            end
            ST_FLUSH: begin
               if (outst_q == '0) state_d = ST_WAIT_SPACE;
            end
            default: state_d = state_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         words_left_q <= '0;
         outst_q      <= '0;
         half_q       <= 1'b0;
         pix_cnt_q    <= '0;
         end_frame_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         words_left_q <= words_left_d;
         outst_q      <= outst_d;
         half_q       <= half_d;
         pix_cnt_q    <= pix_cnt_d;
         end_frame_q  <= end_frame_d;
      end
   end

   assign avl_read       = (state_q == ST_ISSUE);
   assign avl_address    = addr_q;
   assign avl_burstcount = (state_q == ST_ISSUE) ? 8'(BURST_LEN) : 8'd0;
   assign end_frame      = end_frame_q;

   assign unused_bits = ^{reg_addr_buf_1[31:29], reg_addr_buf_2[31:29],
                          fifo_rdata[63:56], fifo_rdata[31:24]};

endmodule

// File: tb/tb_sdram_read_frame.sv
// Bench for sdram_read_frame: an Avalon slave model returns words with a
// fixed latency, expected pixels and burst addresses are queued when each
// frame is started, and independent monitors compare as the DUT presents them.
module tb_sdram_read_frame;
   import sdram_pkg::*;

   localparam int FW  = 64;
   localparam int BL  = 32;
   localparam int FD  = 32;
   localparam int LAT = 20;

   logic        clk, reset_n, start_frame, wr_buf;
   logic [31:0] reg_addr_buf_1, reg_addr_buf_2;
   logic [28:0] avl_address;
   logic [7:0]  avl_burstcount;
   logic        avl_read, avl_waitrequest, avl_readdatavalid;
   logic [63:0] avl_readdata;
   logic [7:0]  r_out, g_out, b_out;
   logic        pix_valid, pix_ready, end_frame;

   typedef struct packed {
      logic [23:0] pix;
      logic        last;
   } exp_t;

   exp_t        exp_q[$];
   logic [28:0] exp_burst_q[$];
   logic [28:0] ret_addr_q[$];
   int          ret_due_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int words_req = 0;
   int stall_left = 0;
   int stall_seen = 0;
   int end_count = 0;

   sdram_read_frame #(
      .FRAME_WORDS (FW),
      .BURST_LEN   (BL),
      .FIFO_DEPTH  (FD)
   ) dut (
      .clk_100           (clk),
      .reset_n           (reset_n),
      .start_frame       (start_frame),
      .wr_buf            (wr_buf),
      .reg_addr_buf_1    (reg_addr_buf_1),
      .reg_addr_buf_2    (reg_addr_buf_2),
      .avl_address       (avl_address),
      .avl_burstcount    (avl_burstcount),
      .avl_read          (avl_read),
      .avl_waitrequest   (avl_waitrequest),
      .avl_readdata      (avl_readdata),
      .avl_readdatavalid (avl_readdatavalid),
      .r_out             (r_out),
      .g_out             (g_out),
      .b_out             (b_out),
      .pix_valid         (pix_valid),
      .pix_ready         (pix_ready),
      .end_frame         (end_frame)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Memory contents seen by the slave model.
   function automatic logic [63:0] word_of(input logic [28:0] a);
      if (a == 29'h1000) return 64'h00332211_00665544;
      return {8'hC3, a[7:0] ^ 8'h5A, a[15:0], 8'h3C, a[15:0], a[7:0] ^ 8'hA5};
   endfunction

   // Expected pixels ({b,g,r}) and burst addresses for one frame at base.
   task automatic push_frame(input logic [28:0] base);
      logic [28:0] a;
      logic [63:0] wd;
      exp_t        e;
      for (int w = 0; w < FW; w++) begin
         a = base + 29'(w);
         e.last = 1'b0;
         if (a == 29'h1000) begin
            // Upper half first: r=11 g=22 b=33, then r=44 g=55 b=66.
            e.pix = 24'h332211;
            exp_q.push_back(e);
            e.pix = 24'h665544;
         end else begin
            wd = word_of(a);
            e.pix = wd[55:32];
            exp_q.push_back(e);
            e.pix = wd[23:0];
         end
         e.last = (w == FW - 1);
         exp_q.push_back(e);
      end
      for (int b = 0; b < FW / BL; b++) exp_burst_q.push_back(base + 29'(b * BL));
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start_frame = 1'b1;
      @(posedge clk); #1;
      start_frame = 1'b0;
   endtask

   task automatic wait_end(input int target, input int budget);
      int n;
      n = 0;
      while (end_count < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      check("end_frame_count", 64'(end_count), 64'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_avl_read"}, 64'(avl_read), 64'd0);
      check({tag, "_avl_address"}, 64'(avl_address), 64'd0);
      check({tag, "_avl_burstcount"}, 64'(avl_burstcount), 64'd0);
      check({tag, "_pix_valid"}, 64'(pix_valid), 64'd0);
      check({tag, "_end_frame"}, 64'(end_frame), 64'd0);
      check({tag, "_rgb"}, 64'({r_out, g_out, b_out}), 64'd0);
   endtask

   // Avalon slave: decides waitrequest, accepts bursts, returns data.
   initial begin
      bit          holding;
      logic [28:0] hold_addr;
      holding           = 1'b0;
      hold_addr         = '0;
      avl_waitrequest   = 1'b0;
      avl_readdatavalid = 1'b0;
      avl_readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
      forever begin
         @(negedge clk);
         if (ret_addr_q.size() > 0 && cyc >= ret_due_q[0]) begin
            avl_readdatavalid = 1'b1;
            avl_readdata      = word_of(ret_addr_q.pop_front());
            void'(ret_due_q.pop_front());
         end else begin
            avl_readdatavalid = 1'b0;
            avl_readdata      = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         if (avl_read) begin
            if (holding) check("addr_hold", 64'(avl_address), 64'(hold_addr));
            if (stall_left > 0) begin
               avl_waitrequest = 1'b1;
               stall_left--;
               stall_seen++;
               holding   = 1'b1;
               hold_addr = avl_address;
            end else begin
               avl_waitrequest = 1'b0;
               holding = 1'b0;
               check("burstcount", 64'(avl_burstcount), 64'(BL));
               if (exp_burst_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL burst_unexpected: got address 0x%0h, expected no burst", avl_address);
               end else begin
                  check("burst_addr", 64'(avl_address), 64'(exp_burst_q.pop_front()));
               end
               words_req += BL;
               for (int i = 0; i < BL; i++) begin
                  ret_addr_q.push_back(avl_address + 29'(i));
                  ret_due_q.push_back(cyc + LAT + i);
               end
            end
         end else begin
            avl_waitrequest = 1'b0;
            holding = 1'b0;
         end
      end
   end

   // Pixel monitor: compares accepted pixels, hold-steady and end_frame timing.
   initial begin
      bit          end_pend, stall_prev;
      logic [23:0] prev_pix;
      exp_t        e;
      end_pend   = 1'b0;
      stall_prev = 1'b0;
      prev_pix   = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            end_pend   = 1'b0;
            stall_prev = 1'b0;
            continue;
         end
         if (end_frame || end_pend) check("end_frame_pulse", 64'(end_frame), 64'(end_pend));
         if (end_frame) end_count++;
         end_pend = 1'b0;
         if (stall_prev && pix_valid) check("pix_hold", 64'({b_out, g_out, r_out}), 64'(prev_pix));
         stall_prev = pix_valid && !pix_ready;
         prev_pix   = {b_out, g_out, r_out};
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pixel_unexpected: got 0x%0h, expected no pixel", {b_out, g_out, r_out});
            end else begin
               e = exp_q.pop_front();
               check("pixel", 64'({b_out, g_out, r_out}), 64'(e.pix));
               end_pend = e.last;
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      int n;
      bit act;
      reset_n = 1'b0;
      start_frame = 1'b0;
      wr_buf = 1'b0;
      reg_addr_buf_1 = '0;
      reg_addr_buf_2 = '0;
      pix_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      reset_n = 1'b1;

      // Plain frame from buffer 1, no stalls, first-pixel latency.
      reg_addr_buf_1 = 32'h0000_1000;
      reg_addr_buf_2 = 32'h0000_2000;
      wr_buf = 1'b1;
      pix_ready = 1'b1;
      push_frame(29'h1000);
      pulse_start();
      n = 0;
      while (!avl_readdatavalid && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      n = 0;
      while (!pix_valid && n < 2) begin
         @(posedge clk); #1;
         n++;
      end
      check("first_pix_latency", 64'(pix_valid), 64'd1);
      wait_end(1, 3000);
      check("frameA_pixels_left", 64'(exp_q.size()), 64'd0);
      check("frameA_bursts_left", 64'(exp_burst_q.size()), 64'd0);

      // Back-pressure for 1000 cycles; base near the top of the address space wraps.
      reg_addr_buf_1 = 32'hFFFF_FFE0;
      words_req = 0;
      pix_ready = 1'b0;
      push_frame(29'h1FFF_FFE0);
      pulse_start();
      repeat (1000) @(posedge clk);
      #1;
      check("credit_words_requested", 64'(words_req), 64'(FD));
      check("credit_read_low", 64'(avl_read), 64'd0);
      pix_ready = 1'b1;
      wait_end(2, 3000);
      check("frameB_pixels_left", 64'(exp_q.size()), 64'd0);

      // Waitrequest held for 10 cycles on the first burst, buffer 2 selected.
      reg_addr_buf_2 = 32'h0000_3000;
      wr_buf = 1'b0;
      stall_seen = 0;
      stall_left = 10;
      push_frame(29'h3000);
      pulse_start();
      wait_end(3, 3000);
      check("stall_cycles", 64'(stall_seen), 64'd10);
      check("frameC_bursts_left", 64'(exp_burst_q.size()), 64'd0);

      // Abort with 32 words outstanding; new base sampled at the restart pulse.
      reg_addr_buf_1 = 32'h0000_1000;
      wr_buf = 1'b1;
      pix_ready = 1'b0;
      words_req = 0;
      exp_burst_q.push_back(29'h1000);
      pulse_start();
      n = 0;
      while (words_req < BL && n < 200) begin
         @(posedge clk);
         n++;
      end
      repeat (5) @(posedge clk);
      #1;
      check("abort_first_burst", 64'(words_req), 64'(BL));
      exp_q.delete();
      exp_burst_q.delete();
      reg_addr_buf_2 = 32'h0000_2000;
      wr_buf = 1'b0;
      push_frame(29'h2000);
      pulse_start();
      wr_buf = 1'b1;
      reg_addr_buf_2 = 32'h0000_5000;
      repeat (100) @(posedge clk);
      #1;
      pix_ready = 1'b1;
      wait_end(4, 3000);
      check("frameD_pixels_left", 64'(exp_q.size()), 64'd0);

      // Asynchronous reset while a burst is returning.
      reg_addr_buf_1 = 32'h0000_1000;
      wr_buf = 1'b1;
      push_frame(29'h1000);
      pulse_start();
      repeat (LAT + 10) @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("midburst_reset");
      exp_q.delete();
      exp_burst_q.delete();
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      act = 1'b0;
      repeat (150) begin
         @(posedge clk); #1;
         if (pix_valid || avl_read) act = 1'b1;
      end
      check("idle_after_reset", 64'(act), 64'd0);
      push_frame(29'h1000);
      pulse_start();
      wait_end(5, 3000);
      check("frameE_pixels_left", 64'(exp_q.size()), 64'd0);
      check("frameE_bursts_left", 64'(exp_burst_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
